// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises one accepted byte per frame as start bit,
// LSB-first data bits, optional even parity bit and stop bit on a registered line.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_serial_out,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_parity;
  logic                 r_serial;
  logic                 r_done;
  logic                 w_tick;
  logic                 w_last_bit;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_serial_nxt;

  assign w_tick     = (r_timer == TIMER_MAX);
  assign w_last_bit = (r_bitcnt == LAST_BIT);
  assign w_accept   = w_ready & i_tx_valid;

  // State register.
  // NOTE: every clocked assignment uses <= so all registers sample pre-edge values together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; encodings outside the enum fall back to IDLE behaviour.
  // NOTE: defaulting w_state_nxt first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_tx_valid) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = S_DATA;
      S_DATA:   if (w_tick && w_last_bit)
                  w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP:   if (w_tick) w_state_nxt = S_IDLE;
      default:  w_state_nxt = i_tx_valid ? S_START : S_IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept)
      w_shift_nxt = i_tx_data;
    else if (r_state == S_DATA && w_tick)
      w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
  end

  // Output decode; the line value is looked up from the state being entered so that
  // the registered pin changes on the same edge as the state.
  always_comb begin
    w_ready      = 1'b1;
    w_serial_nxt = 1'b1;
    case (r_state)
      S_START, S_DATA, S_PARITY, S_STOP: w_ready = 1'b0;
      default:                           w_ready = 1'b1;
    endcase
    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shift_nxt[0];
      S_PARITY: w_serial_nxt = r_parity;
      default:  w_serial_nxt = 1'b1;
    endcase
  end

  // Datapath: bit timer, bit counter, shift register, parity, line and done pulse.
  // NOTE: the shift register and parity are reset too, so no X ever reaches the line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_serial <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_shift  <= w_shift_nxt;
      r_serial <= w_serial_nxt;
      r_done   <= (r_state == S_STOP) && w_tick;
      if (w_accept) begin
        r_timer  <= '0;
        r_bitcnt <= '0;
        r_parity <= ^i_tx_data;
      end else if (w_ready) begin
        r_timer <= '0;
      end else begin
        r_timer <= w_tick ? '0 : r_timer + 1'b1;
        if (r_state == S_DATA && w_tick) r_bitcnt <= r_bitcnt + 1'b1;
      end
    end
  end

  assign o_tx_ready   = w_ready;
  assign o_tx_busy    = ~w_ready;
  assign o_serial_out = r_serial;
  assign o_tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three configurations checked every cycle against a
// frame-level model, plus literal mid-bit captures for known bytes.
module tb_uart_tx_ctrl;

  localparam int N = 3;
  localparam int CPB [N] = '{10, 10, 2};
  localparam int DB  [N] = '{8, 8, 5};
  localparam int PE  [N] = '{0, 1, 0};

  logic         clk;
  logic         n_rst;
  logic [N-1:0] valid;
  logic [8:0]   data [N];
  logic [N-1:0] ser, rdy, bsy, dn;

  int total = 0;
  int bad   = 0;
  logic cmp_en = 1'b0;

  uart_tx_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(0)) u0 (
    .clk(clk), .n_rst(n_rst), .i_tx_valid(valid[0]), .i_tx_data(data[0][7:0]),
    .o_tx_ready(rdy[0]), .o_serial_out(ser[0]), .o_tx_busy(bsy[0]), .o_tx_done(dn[0]));
  uart_tx_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(1)) u1 (
    .clk(clk), .n_rst(n_rst), .i_tx_valid(valid[1]), .i_tx_data(data[1][7:0]),
    .o_tx_ready(rdy[1]), .o_serial_out(ser[1]), .o_tx_busy(bsy[1]), .o_tx_done(dn[1]));
  uart_tx_ctrl #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(0)) u2 (
    .clk(clk), .n_rst(n_rst), .i_tx_valid(valid[2]), .i_tx_data(data[2][4:0]),
    .o_tx_ready(rdy[2]), .o_serial_out(ser[2]), .o_tx_busy(bsy[2]), .o_tx_done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a frame is a list of line bits, each held CPB cycles.
  function automatic logic [11:0] mk_frame(input logic [8:0] d, input int nd, input int p);
    logic [11:0] f;
    logic par;
    f = '0;
    par = 1'b0;
    for (int k = 0; k < nd; k++) begin
      f[k+1] = d[k];
      par ^= d[k];
    end
    if (p != 0) f[nd+1] = par;
    f[nd+1+p] = 1'b1;
    return f;
  endfunction

  function automatic int flen(input int i);
    return (DB[i] + 2 + PE[i]) * CPB[i];
  endfunction

  logic [11:0] mframe [N];
  int          mrem   [N] = '{0, 0, 0};
  logic        mdone  [N] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N; i++) begin
        mrem[i]  <= 0;
        mdone[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        mdone[i] <= (mrem[i] == 1);
        if (mrem[i] > 0) begin
          mrem[i] <= mrem[i] - 1;
        end else if (valid[i]) begin
          mframe[i] <= mk_frame(data[i], DB[i], PE[i]);
          mrem[i]   <= flen(i);
        end
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        logic [3:0] exp;
        if (mrem[i] > 0)
          exp = {mframe[i][(flen(i) - mrem[i]) / CPB[i]], 1'b0, 1'b1, mdone[i]};
        else
          exp = {1'b1, 1'b1, 1'b0, mdone[i]};
        check($sformatf("line_u%0d", i), {ser[i], rdy[i], bsy[i], dn[i]}, exp);
      end
    end
  end

  task automatic wait_idle(input int i);
    int n = 0;
    while (!rdy[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle_timeout_u%0d", i), rdy[i], 1);
  endtask

  // Send one byte and capture the line at the middle of each bit period.
  task automatic run_frame(input int i, input logic [8:0] d,
                           output logic [11:0] bits, output int len, output logic done_ok);
    wait_idle(i);
    valid[i] = 1'b1;
    data[i]  = d;
    @(negedge clk);
    valid[i] = 1'b0;
    len = 0;
    bits = '0;
    done_ok = 1'b1;
    while (!rdy[i] && len < 500) begin
      if ((len % CPB[i]) == CPB[i] / 2 && (len / CPB[i]) < 12) bits[len / CPB[i]] = ser[i];
      if (dn[i]) done_ok = 1'b0;
      len++;
      @(negedge clk);
    end
    if (!dn[i]) done_ok = 1'b0;
  endtask

  initial begin
    logic [11:0] bits;
    int len, gap, dones, cnt;
    logic dok;

    n_rst = 1'b0;
    valid = '0;
    for (int i = 0; i < N; i++) data[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("reset_u%0d", i), {ser[i], rdy[i], bsy[i], dn[i]}, 4'b1100);
    n_rst = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // 0xA5, 8N1 at 10 clocks per bit.
    run_frame(0, 9'h0A5, bits, len, dok);
    check("a5_bits", bits, 12'h34A);
    check("a5_len", len, 100);
    check("a5_done", dok, 1);

    // 0x07 with even parity.
    run_frame(1, 9'h007, bits, len, dok);
    check("p07_bits", bits, 12'h60E);
    check("p07_len", len, 110);
    check("p07_done", dok, 1);

    // 0x13, 5 data bits at 2 clocks per bit.
    run_frame(2, 9'h013, bits, len, dok);
    check("b13_bits", bits, 12'h066);
    check("b13_len", len, 14);
    check("b13_done", dok, 1);

    // tx_valid held high across two frames.
    wait_idle(0);
    valid[0] = 1'b1;
    data[0]  = 9'h055;
    @(negedge clk);
    data[0] = 9'h00F;
    gap = 0;
    dones = 0;
    for (int c = 0; c < 250; c++) begin
      if (c < 200 && rdy[0]) gap++;
      if (dn[0]) dones++;
      if (c == 101) valid[0] = 1'b0;
      @(negedge clk);
    end
    check("b2b_gap", gap, 1);
    check("b2b_dones", dones, 2);

    // tx_valid pulsed mid-frame is ignored.
    wait_idle(0);
    valid[0] = 1'b1;
    data[0]  = 9'h03A;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (40) @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 9'h0FF;
    @(negedge clk);
    valid[0] = 1'b0;
    wait_idle(0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rdy[0]) cnt++;
    end
    check("no_extra_frame", cnt, 0);

    // Reset 35 cycles into a frame.
    valid[0] = 1'b1;
    data[0]  = 9'h096;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (35) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_state", {ser[0], rdy[0], bsy[0], dn[0]}, 4'b1100);
    @(negedge clk);
    #2 n_rst = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn[0]) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    run_frame(0, 9'h03C, bits, len, dok);
    check("r3c_bits", bits, 12'h278);
    check("r3c_len", len, 100);

    // Random traffic on all three instances, including mid-frame data churn.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        valid[i] = ($urandom_range(0, 15) == 0);
        data[i]  = 9'($urandom);
      end
    end
    @(negedge clk);
    valid = '0;
    repeat (300) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
